// File: rtl/vadd_rd_fetch_if.sv
// AXI4 read (AR/R) channels plus the paired-operand stream of the vadd read-fetch stage.
// master = the fetch block, slave = memory interconnect and adder lanes.
interface vadd_rd_fetch_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   m_arid;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [ID_WIDTH-1:0]   m_rid;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  op_valid;
    logic                  op_ready;

    modport master (
        output m_arid, m_araddr, m_arlen, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rvalid,
        output m_rready,
        output op_a, op_b, op_valid,
        input  op_ready
    );

    modport slave (
        input  m_arid, m_araddr, m_arlen, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rvalid,
        input  m_rready,
        input  op_a, op_b, op_valid,
        output op_ready
    );
endinterface

// File: rtl/vadd_rd_fetch.sv
// Read-side fetch of the DDR vector-add kernel: issues A/B AXI read bursts, steers beats by ID
// into two first-word-fall-through operand FIFOs and streams aligned {A,B} pairs downstream.

module vadd_rd_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign count = wr_ptr_r - rd_ptr_r;
endmodule

module vadd_rd_fetch #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_base,
    input  logic [31:0] b_base,
    input  logic [31:0] len_nums,
    output logic        busy,
    output logic        done,
    output logic        rd_err,
    vadd_rd_fetch_if.master bus
);
    localparam int WCNT_W  = 30;
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SPACE_W = OCC_W + 1;
    localparam int BL_W    = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state_r, state_s;
    logic [WCNT_W-1:0]     words_r, pair_cnt_r;
    logic [ADDR_WIDTH-1:0] a_addr_r, b_addr_r;
    logic [WCNT_W-1:0]     a_rem_r, b_rem_r;
    logic [OCC_W-1:0]      a_resv_r, b_resv_r;
    logic                  pref_b_r;
    logic                  ar_valid_r;
    logic [ID_WIDTH-1:0]   ar_id_r;
    logic [ADDR_WIDTH-1:0] ar_addr_r;
    logic [7:0]            ar_len_r;
    logic                  done_r, rd_err_r;

    logic [32:0]           len_round_s;
    logic [WCNT_W-1:0]     words_s;
    logic                  run_s, start_go_s, start_zero_s;
    logic [BL_W-1:0]       start_len_s, a_len_s, b_len_s, iss_len_s;
    logic [SPACE_W-1:0]    a_free_s, b_free_s;
    logic                  a_ok_s, b_ok_s, sel_b_s, ar_slot_s, issue_s;
    logic [ADDR_WIDTH-1:0] iss_addr_s;
    logic [OCC_W-1:0]      a_count_s, b_count_s;
    logic                  a_empty_s, b_empty_s;
    logic [DATA_WIDTH-1:0] a_head_s, b_head_s;
    logic                  r_fire_s, rid_a_s, rid_b_s, push_a_s, push_b_s, overflow_s;
    logic                  op_valid_s, op_fire_s, last_pair_s;
    logic [OCC_W-1:0]      a_add_s, b_add_s, a_sub_s, b_sub_s;

    // Beats a burst may carry: limited by MAX_BURST, the stream remainder and the 4 KB page end.
    function automatic logic [BL_W-1:0] burst_len(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [WCNT_W-1:0]     rem);
        logic [12:0]       page_left;
        logic [WCNT_W-1:0] page_ext;
        logic [WCNT_W-1:0] lim;
        page_left = (13'h1000 - {1'b0, addr[11:0]}) >> 5;
        page_ext  = {{(WCNT_W-13){1'b0}}, page_left};
        lim       = WCNT_W'(MAX_BURST);
        lim       = (page_ext < lim) ? page_ext : lim;
        lim       = (rem < lim) ? rem : lim;
        return lim[BL_W-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] burst_bytes(input logic [BL_W-1:0] beats);
        return {{(ADDR_WIDTH-BL_W-5){1'b0}}, beats, 5'b00000};
    endfunction

    assign len_round_s  = {1'b0, len_nums} + 33'd7;
    assign words_s      = len_round_s[32:3];
    assign run_s        = (state_r == RUN);
    assign start_go_s   = (state_r == IDLE) && start && (words_s != {WCNT_W{1'b0}});
    assign start_zero_s = (state_r == IDLE) && start && (words_s == {WCNT_W{1'b0}});
    assign start_len_s  = burst_len({{(ADDR_WIDTH-32){1'b0}}, a_base}, words_s);

    assign a_len_s  = burst_len(a_addr_r, a_rem_r);
    assign b_len_s  = burst_len(b_addr_r, b_rem_r);
    assign a_free_s = SPACE_W'(FIFO_DEPTH) - {1'b0, a_count_s} - {1'b0, a_resv_r};
    assign b_free_s = SPACE_W'(FIFO_DEPTH) - {1'b0, b_count_s} - {1'b0, b_resv_r};
    assign a_ok_s   = (a_rem_r != {WCNT_W{1'b0}}) && (a_free_s >= SPACE_W'(a_len_s));
    assign b_ok_s   = (b_rem_r != {WCNT_W{1'b0}}) && (b_free_s >= SPACE_W'(b_len_s));

    // Stream choice: take the preferred stream, fall back to the other when it cannot go so a
    // saturated FIFO never starves the stream it is waiting on.
    always_comb begin
        sel_b_s = 1'b0;
        if (pref_b_r) begin
            if (b_ok_s) sel_b_s = 1'b1;
            else        sel_b_s = 1'b0;
        end else begin
            if (a_ok_s) sel_b_s = 1'b0;
            else        sel_b_s = 1'b1;
        end
    end

    assign ar_slot_s  = !ar_valid_r || bus.m_arready;
    assign issue_s    = run_s && ar_slot_s && (sel_b_s ? b_ok_s : a_ok_s);
    assign iss_len_s  = sel_b_s ? b_len_s : a_len_s;
    assign iss_addr_s = sel_b_s ? b_addr_r : a_addr_r;

    assign r_fire_s   = run_s && bus.m_rvalid;
    assign rid_a_s    = (bus.m_rid == ID_WIDTH'(0));
    assign rid_b_s    = (bus.m_rid == ID_WIDTH'(1));
    assign push_a_s   = r_fire_s && rid_a_s && (a_count_s != OCC_W'(FIFO_DEPTH));
    assign push_b_s   = r_fire_s && rid_b_s && (b_count_s != OCC_W'(FIFO_DEPTH));
    assign overflow_s = r_fire_s && ((rid_a_s && !push_a_s) || (rid_b_s && !push_b_s));

    assign op_valid_s  = run_s && !a_empty_s && !b_empty_s;
    assign op_fire_s   = op_valid_s && bus.op_ready;
    assign last_pair_s = op_fire_s && (pair_cnt_r == (words_r - WCNT_W'(1)));

    assign a_add_s = (issue_s && !sel_b_s) ? OCC_W'(iss_len_s) : {OCC_W{1'b0}};
    assign b_add_s = (issue_s &&  sel_b_s) ? OCC_W'(iss_len_s) : {OCC_W{1'b0}};
    assign a_sub_s = (push_a_s && (a_resv_r != {OCC_W{1'b0}})) ? OCC_W'(1) : {OCC_W{1'b0}};
    assign b_sub_s = (push_b_s && (b_resv_r != {OCC_W{1'b0}})) ? OCC_W'(1) : {OCC_W{1'b0}};

    vadd_rd_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst), .push(push_a_s), .wdata(bus.m_rdata), .pop(op_fire_s),
        .rdata(a_head_s), .empty(a_empty_s), .count(a_count_s)
    );

    vadd_rd_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst), .push(push_b_s), .wdata(bus.m_rdata), .pop(op_fire_s),
        .rdata(b_head_s), .empty(b_empty_s), .count(b_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // FSM next state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_go_s) state_s = RUN;
                else            state_s = IDLE;
            end
            RUN: begin
                if (last_pair_s) state_s = IDLE;
                else             state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Job latch, per-stream issue pointers and the AR output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_r    <= {WCNT_W{1'b0}};
            a_addr_r   <= {ADDR_WIDTH{1'b0}};
            b_addr_r   <= {ADDR_WIDTH{1'b0}};
            a_rem_r    <= {WCNT_W{1'b0}};
            b_rem_r    <= {WCNT_W{1'b0}};
            pref_b_r   <= 1'b0;
            ar_valid_r <= 1'b0;
            ar_id_r    <= {ID_WIDTH{1'b0}};
            ar_addr_r  <= {ADDR_WIDTH{1'b0}};
            ar_len_r   <= 8'd0;
        end else if (start_go_s) begin
            // The first A burst leaves on the same cycle busy rises; the FIFOs are empty here.
            words_r    <= words_s;
            a_addr_r   <= {{(ADDR_WIDTH-32){1'b0}}, a_base} + burst_bytes(start_len_s);
            a_rem_r    <= words_s - WCNT_W'(start_len_s);
            b_addr_r   <= {{(ADDR_WIDTH-32){1'b0}}, b_base};
            b_rem_r    <= words_s;
            pref_b_r   <= 1'b1;
            ar_valid_r <= 1'b1;
            ar_id_r    <= ID_WIDTH'(0);
            ar_addr_r  <= {{(ADDR_WIDTH-32){1'b0}}, a_base};
            ar_len_r   <= 8'(start_len_s) - 8'd1;
        end else if (issue_s) begin
            ar_valid_r <= 1'b1;
            ar_id_r    <= sel_b_s ? ID_WIDTH'(1) : ID_WIDTH'(0);
            ar_addr_r  <= iss_addr_s;
            ar_len_r   <= 8'(iss_len_s) - 8'd1;
            pref_b_r   <= !sel_b_s;
            if (sel_b_s) begin
                b_addr_r <= b_addr_r + burst_bytes(iss_len_s);
                b_rem_r  <= b_rem_r - WCNT_W'(iss_len_s);
            end else begin
                a_addr_r <= a_addr_r + burst_bytes(iss_len_s);
                a_rem_r  <= a_rem_r - WCNT_W'(iss_len_s);
            end
        end else if (bus.m_arready) begin
            ar_valid_r <= 1'b0;
        end else begin
            ar_valid_r <= ar_valid_r;
        end
    end

    // Reserved FIFO space: grows when a burst is committed, shrinks as its beats land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_resv_r <= {OCC_W{1'b0}};
            b_resv_r <= {OCC_W{1'b0}};
        end else if (start_go_s) begin
            a_resv_r <= OCC_W'(start_len_s);
            b_resv_r <= {OCC_W{1'b0}};
        end else begin
            a_resv_r <= a_resv_r + a_add_s - a_sub_s;
            b_resv_r <= b_resv_r + b_add_s - b_sub_s;
        end
    end

    // Pair counter, completion pulse and sticky read-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt_r <= {WCNT_W{1'b0}};
            done_r     <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            done_r <= start_zero_s || last_pair_s;
            if (start_go_s) begin
                pair_cnt_r <= {WCNT_W{1'b0}};
                rd_err_r   <= 1'b0;
            end else begin
                if (op_fire_s) pair_cnt_r <= pair_cnt_r + WCNT_W'(1);
                if (r_fire_s && ((!rid_a_s && !rid_b_s) || (bus.m_rresp != 2'b00) || overflow_s)) begin
                    rd_err_r <= 1'b1;
                end
            end
        end
    end

    assign busy          = run_s;
    assign done          = done_r;
    assign rd_err        = rd_err_r;
    assign bus.m_arid    = ar_id_r;
    assign bus.m_araddr  = ar_addr_r;
    assign bus.m_arlen   = ar_len_r;
    assign bus.m_arvalid = ar_valid_r;
    assign bus.m_rready  = run_s;
    assign bus.op_a      = a_head_s;
    assign bus.op_b      = b_head_s;
    assign bus.op_valid  = op_valid_s;
endmodule

// File: tb/tb_vadd_rd_fetch.sv
// Bench for vadd_rd_fetch: AXI read slave model, randomised ready/valid and a pair scoreboard.
module tb_vadd_rd_fetch;
    localparam int DW = 256;
    localparam int AW = 64;
    localparam int IW = 4;

    typedef struct packed { logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_base, b_base, len_nums;
    logic        busy, done, rd_err;

    vadd_rd_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    vadd_rd_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST(16), .FIFO_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a_base(a_base), .b_base(b_base), .len_nums(len_nums),
        .busy(busy), .done(done), .rd_err(rd_err), .bus(bus)
    );

    always #5 clk = ~clk;

    ar_t         exp_ar[$];
    pair_t       exp_pairs[$];
    logic [AW-1:0] qa[$];
    logic [AW-1:0] qb[$];
    bit          ar_check = 1'b0, ar_rand = 1'b1, rmode = 1'b0, op_hold = 1'b0, err_inject = 1'b0;
    bit          job_active = 1'b0;
    int          ar_beats_a = 0, ar_beats_b = 0;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = addr[31:0] ^ (32'(i) << 24) ^ 32'h0055_AA00;
        return w;
    endfunction

    // Slave model and consumer: everything decided on the falling edge, handshakes resolved one edge later.
    initial begin : slave
        bit ar_off, r_off, op_off, pick_b;
        ar_t cap_ar, e;
        pair_t p;
        logic [DW-1:0] cap_a, cap_b;
        logic [AW-1:0] addr;
        ar_off = 1'b0; r_off = 1'b0; op_off = 1'b0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rid = '0; bus.m_rdata = '0;
        bus.m_rresp = 2'b00; bus.op_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                qa.delete(); qb.delete();
                bus.m_rvalid = 1'b0; ar_off = 1'b0; r_off = 1'b0; op_off = 1'b0;
                continue;
            end
            if (ar_off) begin
                for (int k = 0; k <= int'(cap_ar.len); k++) begin
                    if (cap_ar.id == IW'(0)) qa.push_back(cap_ar.addr + AW'(32 * k));
                    else                     qb.push_back(cap_ar.addr + AW'(32 * k));
                end
                if (cap_ar.id == IW'(0)) ar_beats_a += int'(cap_ar.len) + 1;
                else                     ar_beats_b += int'(cap_ar.len) + 1;
                if (ar_check) begin
                    n_checks++;
                    if (exp_ar.size() == 0) begin
                        n_fail++;
                        $display("FAIL ar_extra got id=%0d addr=%h len=%0d required none", cap_ar.id, cap_ar.addr, cap_ar.len);
                    end else begin
                        e = exp_ar.pop_front();
                        if (cap_ar !== e) begin
                            n_fail++;
                            $display("FAIL ar_order got id=%0d addr=%h len=%0d required id=%0d addr=%h len=%0d",
                                     cap_ar.id, cap_ar.addr, cap_ar.len, e.id, e.addr, e.len);
                        end
                    end
                end
            end
            if (r_off) bus.m_rvalid = 1'b0;
            if (op_off) begin
                n_checks++;
                if (exp_pairs.size() == 0) begin
                    n_fail++;
                    $display("FAIL pair_extra got a=%h required none", cap_a);
                end else begin
                    p = exp_pairs.pop_front();
                    if (cap_a !== p.a || cap_b !== p.b) begin
                        n_fail++;
                        $display("FAIL pair_data got a=%h b=%h required a=%h b=%h", cap_a, cap_b, p.a, p.b);
                    end
                    if (exp_pairs.size() == 0 && job_active) begin
                        n_checks++;
                        if (done !== 1'b1 || busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL done_after_last got done=%b busy=%b required done=1 busy=0", done, busy);
                        end
                    end
                end
            end
            bus.m_arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!bus.m_rvalid && (qa.size() > 0 || qb.size() > 0) && ($urandom_range(0, 4) != 0)) begin
                if (rmode) pick_b = (qb.size() > 0) && ((qa.size() == 0) || ($urandom_range(0, 3) != 0));
                else       pick_b = (qa.size() == 0);
                addr = pick_b ? qb.pop_front() : qa.pop_front();
                bus.m_rid   = pick_b ? IW'(1) : IW'(0);
                bus.m_rdata = mem_word(addr);
                bus.m_rresp = 2'b00;
                if (!pick_b && err_inject) begin
                    bus.m_rresp = 2'b10;
                    err_inject  = 1'b0;
                end
                bus.m_rvalid = 1'b1;
            end
            bus.op_ready = op_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            ar_off = bus.m_arvalid && bus.m_arready;
            cap_ar = '{id: bus.m_arid, addr: bus.m_araddr, len: bus.m_arlen};
            r_off  = bus.m_rvalid && bus.m_rready;
            op_off = bus.op_valid && bus.op_ready;
            cap_a  = bus.op_a;
            cap_b  = bus.op_b;
        end
    end

    task automatic push_pairs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        int words;
        words = int'((n + 32'd7) >> 3);
        for (int i = 0; i < words; i++)
            exp_pairs.push_back('{a: mem_word(AW'(a) + AW'(32 * i)), b: mem_word(AW'(b) + AW'(32 * i))});
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                           input logic exp_err, input string tag);
        bit got;
        push_pairs(a, b, n);
        job_active = 1'b1;
        @(negedge clk);
        a_base = a; b_base = b; len_nums = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || bus.m_arvalid !== 1'b1 || bus.m_arid !== IW'(0) || bus.m_araddr !== AW'(a)) begin
            n_fail++;
            $display("FAIL %s_first_ar got busy=%b arvalid=%b arid=%0d araddr=%h required 1 1 0 %h",
                     tag, busy, bus.m_arvalid, bus.m_arid, bus.m_araddr, AW'(a));
        end
        got = 1'b0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_timeout got no done required done within 4000 cycles", tag);
        end
        @(negedge clk);
        job_active = 1'b0;
        n_checks++;
        if (exp_pairs.size() != 0 || rd_err !== exp_err || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end got left=%0d rd_err=%b busy=%b done=%b required left=0 rd_err=%b busy=0 done=0",
                     tag, exp_pairs.size(), rd_err, busy, done, exp_err);
        end
        if (ar_check) begin
            n_checks++;
            if (exp_ar.size() != 0) begin
                n_fail++;
                $display("FAIL %s_ar_missing got %0d unissued required 0", tag, exp_ar.size());
            end
        end
        exp_pairs.delete();
        exp_ar.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_base = '0; b_base = '0; len_nums = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_err !== 1'b0 || bus.m_arvalid !== 1'b0 || bus.m_rready !== 1'b0 ||
            bus.op_valid !== 1'b0 || bus.m_arid !== '0 || bus.m_araddr !== '0 || bus.m_arlen !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values got busy=%b done=%b err=%b arv=%b rr=%b opv=%b id=%0d addr=%h len=%0d required all 0",
                     busy, done, rd_err, bus.m_arvalid, bus.m_rready, bus.op_valid, bus.m_arid, bus.m_araddr, bus.m_arlen);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        ar_check = 1'b1;
        exp_ar.push_back('{id: IW'(0), addr: AW'(32'h8000_0000), len: 8'd7});
        exp_ar.push_back('{id: IW'(1), addr: AW'(32'h8000_0100), len: 8'd7});
        run_job(32'h8000_0000, 32'h8000_0100, 32'd64, 1'b0, "basic");
        ar_check = 1'b0;
    endtask

    task automatic test_4k_split();
        ar_check = 1'b1;
        exp_ar.push_back('{id: IW'(0), addr: AW'(32'h8000_0F80), len: 8'd3});
        exp_ar.push_back('{id: IW'(1), addr: AW'(32'h8000_2000), len: 8'd15});
        exp_ar.push_back('{id: IW'(0), addr: AW'(32'h8000_1000), len: 8'd11});
        run_job(32'h8000_0F80, 32'h8000_2000, 32'd128, 1'b0, "split4k");
        ar_check = 1'b0;
    endtask

    task automatic test_edge_lengths();
        @(negedge clk);
        len_nums = 32'd0; a_base = 32'h8000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done got done=%b busy=%b arvalid=%b required 1 0 0", done, busy, bus.m_arvalid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_after got done=%b busy=%b arvalid=%b required 0 0 0", done, busy, bus.m_arvalid);
        end
        ar_check = 1'b1;
        exp_ar.push_back('{id: IW'(0), addr: AW'(32'h8000_4000), len: 8'd1});
        exp_ar.push_back('{id: IW'(1), addr: AW'(32'h8000_5000), len: 8'd1});
        run_job(32'h8000_4000, 32'h8000_5000, 32'd9, 1'b0, "len9");
        ar_check = 1'b0;
    endtask

    task automatic test_errors();
        err_inject = 1'b1;
        run_job(32'h8000_0000, 32'h8000_0100, 32'd64, 1'b1, "rresp_err");
    endtask

    task automatic test_interleaved();
        rmode = 1'b1;
        run_job(32'h8000_6000, 32'h8000_7020, 32'd256, 1'b0, "interleave");
    endtask

    task automatic test_back_to_back();
        run_job(32'h8000_0040, 32'h8000_0FE0, 32'd100, 1'b0, "b2b_1");
        run_job(32'h8000_0FE0, 32'h8000_0040, 32'd33, 1'b0, "b2b_2");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held_a;
        op_hold = 1'b1;
        ar_beats_a = 0; ar_beats_b = 0;
        fork
            run_job(32'h8000_0000, 32'h8001_0000, 32'd1024, 1'b0, "backpressure");
            begin
                repeat (100) @(negedge clk);
                held_a = bus.op_a;
                repeat (100) @(negedge clk);
                n_checks++;
                if (ar_beats_a != 32 || ar_beats_b != 32 || bus.op_valid !== 1'b1 || bus.op_a !== held_a) begin
                    n_fail++;
                    $display("FAIL bp_hold got beats_a=%0d beats_b=%0d op_valid=%b stable=%b required 32 32 1 1",
                             ar_beats_a, ar_beats_b, bus.op_valid, bus.op_a === held_a);
                end
                op_hold = 1'b0;
            end
        join
    endtask

    task automatic test_rst_mid_job();
        push_pairs(32'h8000_0000, 32'h8000_8000, 32'd1024);
        @(negedge clk);
        a_base = 32'h8000_0000; b_base = 32'h8000_8000; len_nums = 32'd1024; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.op_valid !== 1'b0 || bus.m_rready !== 1'b0 || bus.m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_job got busy=%b op_valid=%b rready=%b arvalid=%b required 0 0 0 0",
                     busy, bus.op_valid, bus.m_rready, bus.m_arvalid);
        end
        exp_pairs.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        run_job(32'h8000_0000, 32'h8000_0100, 32'd64, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_split();
        test_edge_lengths();
        test_errors();
        test_interleaved();
        test_back_to_back();
        test_backpressure();
        test_rst_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
